led_pattern_gen: RTL and testbench
==================================

Name: led_pattern_gen

Overview:
Multi-channel, run-time configurable LED driver; the successor to the single fixed-rate blinker. A shared prescaler derives a slow tick from the system clock. Each of N_CH channels runs its own mode: OFF, ON, BLINK with per-channel half-period, or ONESHOT (single timed pulse). It sits between a simple register-write port, from a CSR block or CPU bridge, and the board LED pins.

Parameters:
CLK_FREQ_KHz, 50000, system clock frequency in kHz
TICK_FREQ_Hz, 1000, prescaler tick rate in Hz; TICK_DIV = (CLK_FREQ_KHz*1000)/TICK_FREQ_Hz, must be >= 2
N_CH, 4, number of LED channels, 1..32
HALF_W, 16, width of per-channel half-period field, in ticks
RST_HALF, 500, half-period loaded into every channel at reset (1 Hz blink at default tick)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
cfg_we  in  1  one-cycle configuration write strobe
cfg_ch  in  clog2(N_CH) (min 1)  target channel index
cfg_mode  in  2  00 OFF, 01 ON, 10 BLINK, 11 ONESHOT
cfg_half  in  HALF_W  half-period / pulse length, in ticks
led  out  N_CH  registered LED drive, bit i = channel i
done  out  N_CH  one-cycle pulse when a channel's ONESHOT expires

Behaviour:
- Reset: prescaler count 0; every channel mode=BLINK, half=RST_HALF, cnt=0, phase=1. led = all ones; done = 0.
- Prescaler: counter 0..TICK_DIV-1, wraps to 0. Internal tick is high for exactly the one cycle in which count==TICK_DIV-1. Width = clog2(TICK_DIV).
- Config write (cfg_we=1, cfg_ch<N_CH): channel loads mode and half. cfg_half==0 is stored as 1. cnt is cleared to 0.
- phase on write: ONESHOT or BLINK gives 1; ON gives 1; OFF gives 0.
- Write effect: led updates on the next clock edge (1-cycle latency).
- Writes with cfg_ch>=N_CH are ignored silently.
- Write-vs-tick conflict: a write on the same cycle as a tick wins; that tick is lost for that channel only.
- Per-channel state on tick:
  - OFF / ON: hold; cnt stays 0.
  - BLINK: if cnt==half-1, then cnt <= 0 and phase toggles; else cnt <= cnt+1.
  - ONESHOT: if cnt==half-1, then phase <= 0, mode <= OFF, cnt <= 0, done[i] pulses high for the next cycle only; else cnt <= cnt+1.
- led[i] = phase register (no combinational path from inputs).
- Rewriting a channel mid-ONESHOT restarts it. No done pulse is issued for the aborted pulse.
- rst asserted at any time overrides writes and ticks and returns all channels to reset state on the next edge.
- Arithmetic: cnt is HALF_W bits, unsigned; it can never exceed half-1, so no overflow.

Optional Feature:
LED_ACTIVE_LOW_EN: when defined, the led port is driven with the inverse of phase, including at reset (led = all zeros after reset) for active-low board wiring. Internal state and done are unchanged. When undefined, led = phase.

Decomposition:
- Shared package/defs header holds:
  - mode encodings MODE_OFF=2'b00, MODE_ON=2'b01, MODE_BLINK=2'b10, MODE_ONESHOT=2'b11
  - the clog2 function
  - the TICK_DIV derivation
- Sub-module led_channel (one instance per channel, generate loop):
  - inputs: clk, rst, tick, wr, mode, half
  - outputs: led_bit, done_bit
  - parameters: HALF_W, RST_HALF
- The top holds only the prescaler, the write address decode and the optional inversion.

Test Plan:
All cases use CLK_FREQ_KHz=1, TICK_FREQ_Hz=100 (TICK_DIV=10), N_CH=4, HALF_W=8, RST_HALF=3.
- Reset release -> led=4'b1111, done=0. With a tick every 10 clocks, each led toggles every 30 clocks (first toggle at the 3rd tick), phase-aligned across channels.
- Write ch2 OFF, then ch1 ON -> cycle after each write: led[2]=0, led[1]=1. Both hold for 200 clocks while ch0/ch3 keep blinking.
- Write ch0 ONESHOT half=2 -> led[0]=1 next cycle, falls after the 2nd subsequent tick. done[0] high for exactly 1 cycle, coincident with the fall. Then led[0] stays 0.
- Write ch3 BLINK half=0 -> treated as 1; led[3] toggles on every tick (period 20 clocks).
- cfg_we with cfg_ch=3 issued on the tick cycle -> that tick is not counted for ch3; other channels advance normally.
- Assert rst for 1 cycle mid-ONESHOT on ch0 -> all channels back to BLINK half=3, led=4'b1111, no done pulse. Rerun with LED_ACTIVE_LOW_EN -> led inverted, done identical.

Source files
------------

// File: rtl/led_pattern_gen_pkg.sv
// Shared definitions for the LED pattern generator: channel modes and
// the parameter-derivation helpers used by the top and the channels.
package led_pattern_gen_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_ON      = 2'b01,
        MODE_BLINK   = 2'b10,
        MODE_ONESHOT = 2'b11
    } mode_e;

    // Smallest w with 2**w >= value; 0 for value <= 1.
    function automatic int clog2(input longint unsigned value);
        int width;
        width = 0;
        while ((64'd1 << width) < value) begin
            width = width + 1;
        end
        return width;
    endfunction

    // A one-channel build still needs a 1-bit channel index.
    function automatic int ch_width(input int n_ch);
        return (clog2(longint'(n_ch)) < 1) ? 1 : clog2(longint'(n_ch));
    endfunction

    function automatic int calc_tick_div(input int clk_freq_khz, input int tick_freq_hz);
        return (clk_freq_khz * 1000) / tick_freq_hz;
    endfunction

endpackage

// File: rtl/led_channel.sv
// One LED channel: mode, half-period, tick counter and phase, with a
// registered LED bit and a one-cycle done pulse when a ONESHOT expires.
module led_channel
    import led_pattern_gen_pkg::*;
#(
    parameter int HALF_W   = 16,
    parameter int RST_HALF = 500
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              wr,
    input  logic [1:0]        mode,
    input  logic [HALF_W-1:0] half,
    output logic              led_bit,
    output logic              done_bit
);

    mode_e             mode_q, mode_d;
    logic [HALF_W-1:0] half_q, half_d;
    logic [HALF_W-1:0] cnt_q, cnt_d;
    logic              phase_q, phase_d;
    logic              done_q, done_d;
    logic              at_end;

    // A write always wins over a coinciding tick, so that tick is simply lost here.
    always_comb begin
        mode_d  = mode_q;
        half_d  = half_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        done_d  = 1'b0;
        at_end  = (cnt_q == (half_q - HALF_W'(1)));
        if (wr) begin
            mode_d  = mode_e'(mode);
            half_d  = (half == '0) ? HALF_W'(1) : half;
            cnt_d   = '0;
            phase_d = (mode_e'(mode) != MODE_OFF);
        end else if (tick) begin
            case (mode_q)
                MODE_BLINK: begin
                    if (at_end) begin
                        cnt_d   = '0;
                        phase_d = ~phase_q;
                    end else begin
                        cnt_d = cnt_q + HALF_W'(1);
                    end
                end
                MODE_ONESHOT: begin
                    if (at_end) begin
                        cnt_d   = '0;
                        phase_d = 1'b0;
                        mode_d  = MODE_OFF;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + HALF_W'(1);
                    end
                end
                default: cnt_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= MODE_BLINK;
            half_q  <= HALF_W'(RST_HALF);
            cnt_q   <= '0;
            phase_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            half_q  <= half_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            done_q  <= done_d;
        end
    end

    assign led_bit  = phase_q;
    assign done_bit = done_q;

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: shared tick prescaler, write decode
// and per-channel engines. Define LED_ACTIVE_LOW_EN for active-low LED pins.
module led_pattern_gen
    import led_pattern_gen_pkg::*;
#(
    parameter int CLK_FREQ_KHz = 50000,
    parameter int TICK_FREQ_Hz = 1000,
    parameter int N_CH         = 4,
    parameter int HALF_W       = 16,
    parameter int RST_HALF     = 500
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_we,
    input  logic [ch_width(N_CH)-1:0] cfg_ch,
    input  logic [1:0]                cfg_mode,
    input  logic [HALF_W-1:0]         cfg_half,
    output logic [N_CH-1:0]           led,
    output logic [N_CH-1:0]           done
);

    localparam int TICK_DIV = calc_tick_div(CLK_FREQ_KHz, TICK_FREQ_Hz);
    localparam int PRESC_W  = clog2(longint'(TICK_DIV));
    localparam int CH_W     = ch_width(N_CH);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               tick;
    logic [N_CH-1:0]    wr;
    logic [N_CH-1:0]    phase;

    always_comb begin
        tick    = (presc_q == PRESC_LAST);
        presc_d = tick ? '0 : presc_q + PRESC_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    // Indices at or beyond N_CH match no channel, so such writes vanish.
    always_comb begin
        wr = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (cfg_we && (cfg_ch == CH_W'(i))) begin
                wr[i] = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        led_channel #(
            .HALF_W   (HALF_W),
            .RST_HALF (RST_HALF)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .tick     (tick),
            .wr       (wr[g]),
            .mode     (cfg_mode),
            .half     (cfg_half),
            .led_bit  (phase[g]),
            .done_bit (done[g])
        );
    end

`ifdef LED_ACTIVE_LOW_EN
    assign led = ~phase;
`else
    assign led = phase;
`endif

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed, table-driven bench for led_pattern_gen (TICK_DIV=10, 4 channels,
// reset half-period 3); expected LED values follow LED_ACTIVE_LOW_EN.
module tb_led_pattern_gen;

    localparam logic [3:0] INV =
`ifdef LED_ACTIVE_LOW_EN
        4'hF;
`else
        4'h0;
`endif

    logic       clk;
    logic       rst;
    logic       cfg_we;
    logic [1:0] cfg_ch;
    logic [1:0] cfg_mode;
    logic [7:0] cfg_half;
    logic [3:0] led;
    logic [3:0] done;

    int errors = 0;
    int checks = 0;
    int cur    = 0;

    typedef struct {
        int         n;
        logic       we;
        logic [1:0] ch;
        logic [1:0] mode;
        logic [7:0] half;
        logic [3:0] exp_led;
        logic [3:0] exp_done;
    } vec_t;

    vec_t vecs[$];

    led_pattern_gen #(
        .CLK_FREQ_KHz (1),
        .TICK_FREQ_Hz (100),
        .N_CH         (4),
        .HALF_W       (8),
        .RST_HALF     (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_mode (cfg_mode),
        .cfg_half (cfg_half),
        .led      (led),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and sample 1 ns later; any write strobe lasts one edge.
    task automatic step_clock();
        @(posedge clk);
        #1;
        cur++;
        cfg_we = 1'b0;
    endtask

    task automatic apply_stimulus(input logic we, input logic [1:0] ch,
                                  input logic [1:0] mode, input logic [7:0] half);
        cfg_we   = we;
        cfg_ch   = ch;
        cfg_mode = mode;
        cfg_half = half;
    endtask

    task automatic check_output(input string name, input logic [3:0] exp_led,
                                input logic [3:0] exp_done);
        checks++;
        if (led !== (exp_led ^ INV)) begin
            errors++;
            $display("[TB] FAIL %s led @%0d: got %b expected %b", name, cur, led, exp_led ^ INV);
        end
        checks++;
        if (done !== exp_done) begin
            errors++;
            $display("[TB] FAIL %s done @%0d: got %b expected %b", name, cur, done, exp_done);
        end
    endtask

    task automatic add_vec(input int n, input logic we, input logic [1:0] ch, input logic [1:0] mode,
                           input logic [7:0] half, input logic [3:0] exp_led, input logic [3:0] exp_done);
        vec_t v;
        v.n = n; v.we = we; v.ch = ch; v.mode = mode; v.half = half;
        v.exp_led = exp_led; v.exp_done = exp_done;
        vecs.push_back(v);
    endtask

    initial begin
        // Point n = sampled n edges after reset release; ticks land on edges 10, 20, ...
        add_vec(0,   0, 0, 2'b00, 8'd0, 4'b1111, 4'b0000);
        add_vec(29,  0, 0, 2'b00, 8'd0, 4'b1111, 4'b0000);
        add_vec(30,  0, 0, 2'b00, 8'd0, 4'b0000, 4'b0000);
        add_vec(59,  0, 0, 2'b00, 8'd0, 4'b0000, 4'b0000);
        add_vec(60,  0, 0, 2'b00, 8'd0, 4'b1111, 4'b0000);
        add_vec(61,  1, 2, 2'b00, 8'd5, 4'b1111, 4'b0000);
        add_vec(62,  0, 0, 2'b00, 8'd0, 4'b1011, 4'b0000);
        add_vec(89,  0, 0, 2'b00, 8'd0, 4'b1011, 4'b0000);
        add_vec(90,  0, 0, 2'b00, 8'd0, 4'b0000, 4'b0000);
        add_vec(91,  1, 1, 2'b01, 8'd9, 4'b0000, 4'b0000);
        add_vec(92,  0, 0, 2'b00, 8'd0, 4'b0010, 4'b0000);
        add_vec(120, 0, 0, 2'b00, 8'd0, 4'b1011, 4'b0000);
        add_vec(150, 0, 0, 2'b00, 8'd0, 4'b0010, 4'b0000);
        add_vec(290, 0, 0, 2'b00, 8'd0, 4'b0010, 4'b0000);
        add_vec(300, 0, 0, 2'b00, 8'd0, 4'b1011, 4'b0000);
        add_vec(330, 0, 0, 2'b00, 8'd0, 4'b0010, 4'b0000);
        add_vec(331, 1, 0, 2'b11, 8'd2, 4'b0010, 4'b0000);
        add_vec(332, 0, 0, 2'b00, 8'd0, 4'b0011, 4'b0000);
        add_vec(349, 0, 0, 2'b00, 8'd0, 4'b0011, 4'b0000);
        add_vec(350, 0, 0, 2'b00, 8'd0, 4'b0010, 4'b0001);
        add_vec(351, 0, 0, 2'b00, 8'd0, 4'b0010, 4'b0000);
        add_vec(360, 0, 0, 2'b00, 8'd0, 4'b1010, 4'b0000);
        add_vec(400, 0, 0, 2'b00, 8'd0, 4'b0010, 4'b0000);
        add_vec(401, 1, 3, 2'b10, 8'd0, 4'b0010, 4'b0000);
        add_vec(402, 0, 0, 2'b00, 8'd0, 4'b1010, 4'b0000);
        add_vec(409, 0, 0, 2'b00, 8'd0, 4'b1010, 4'b0000);
        add_vec(410, 0, 0, 2'b00, 8'd0, 4'b0010, 4'b0000);
        add_vec(420, 0, 0, 2'b00, 8'd0, 4'b1010, 4'b0000);
        add_vec(430, 0, 0, 2'b00, 8'd0, 4'b0010, 4'b0000);
        add_vec(439, 1, 3, 2'b10, 8'd2, 4'b0010, 4'b0000);
        add_vec(440, 0, 0, 2'b00, 8'd0, 4'b1010, 4'b0000);
        add_vec(450, 0, 0, 2'b00, 8'd0, 4'b1010, 4'b0000);
        add_vec(459, 0, 0, 2'b00, 8'd0, 4'b1010, 4'b0000);
        add_vec(460, 0, 0, 2'b00, 8'd0, 4'b0010, 4'b0000);
        add_vec(461, 1, 0, 2'b11, 8'd3, 4'b0010, 4'b0000);
        add_vec(462, 0, 0, 2'b00, 8'd0, 4'b0011, 4'b0000);
        add_vec(475, 0, 0, 2'b00, 8'd0, 4'b0011, 4'b0000);

        rst = 1'b1;
        apply_stimulus(1'b0, 2'd0, 2'b00, 8'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        cur = 0;

        foreach (vecs[i]) begin
            while (cur < vecs[i].n) step_clock();
            check_output($sformatf("vec%0d", i), vecs[i].exp_led, vecs[i].exp_done);
            if (vecs[i].we) apply_stimulus(1'b1, vecs[i].ch, vecs[i].mode, vecs[i].half);
        end

        // One-cycle reset mid-ONESHOT on ch0: back to reset state, the pending pulse never reports done.
        rst = 1'b1;
        step_clock();
        rst = 1'b0;
        check_output("rst_mid_oneshot", 4'b1111, 4'b0000);
        for (int k = 1; k < 30; k++) begin
            step_clock();
            check_output($sformatf("post_rst_%0d", k), 4'b1111, 4'b0000);
        end
        step_clock();
        check_output("post_rst_toggle", 4'b0000, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
